// File: rtl/regset_arbiter_pkg.sv
// regset_pkg: shared definitions for the regset block and its port arbiter.
//   ADDR_W / DATA_W      default regset bus widths
//   DATA0_ADDR           read/write data register
//   DATA0_SR_ADDR        read-only status mirror of DATA0
//   arb_state_t          arbiter sequencing states
//   addr_aligned()       word-alignment test on the two address LSBs
package regset_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] DATA0_ADDR    = 10'h000;
  localparam logic [ADDR_W-1:0] DATA0_SR_ADDR = 10'h004;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  function automatic logic addr_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/regset_arbiter_if.sv
// Interfaces around the regset arbiter.
//   regset_req_if : requester side (valid/ready command, one-cycle response pulse)
//     master = requesters, slave = arbiter
//     req_valid/req_write/req_addr/req_wdata  command fields, packed per requester
//     req_ready                               command accepted (one-hot or zero)
//     rsp_valid/rsp_err/rsp_rdata             response, rsp_err/rsp_rdata shared
//   regset_bus_if : regset register port
//     master = arbiter, slave = regset
//     wr_en/rd_en/addr/wdata                  access strobes and fields
//     rdata                                   combinational read data
interface regset_req_if
  import regset_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = regset_pkg::ADDR_W,
  parameter int DATA_W  = regset_pkg::DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic                      rsp_err;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

interface regset_bus_if
  import regset_pkg::*;
#(
  parameter int ADDR_W = regset_pkg::ADDR_W,
  parameter int DATA_W = regset_pkg::DATA_W
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output wr_en, rd_en, addr, wdata,
    input  rdata
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/regset_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   i_req    request vector
//   i_ptr    index of the most recent winner; search starts at i_ptr+1
//   o_grant  one-hot grant (zero when no request)
//   o_idx    index of the granted requester
//   o_any    at least one request present
// The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin
    int cand;
    cand    = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // offset NUM_REQ wraps back to the pointer itself, so the last winner is
    // considered only after every other requester.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(i_ptr) + off) % NUM_REQ;
      if (!o_any && i_req[IDX_W'(cand)]) begin
        o_any                   = 1'b1;
        o_idx                   = IDX_W'(cand);
        o_grant[IDX_W'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regset_arbiter.sv
// regset_arbiter: round-robin sharing of one regset register port among
// NUM_REQ requesters. One command in flight; accept -> bus -> response.
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   req_if   requester side (slave modport)
//   bus_if   regset port (master modport), all outputs registered
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | arbitrate; winner sees req_ready and is latched at posedge
//   ISSUE | bus access driven (or suppressed if misaligned); rdata sampled
//   RESP  | rsp_valid pulse to the latched winner
module regset_arbiter
  import regset_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = regset_pkg::ADDR_W,
  parameter int DATA_W  = regset_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  regset_req_if.slave   req_if,
  regset_bus_if.master  bus_if
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_RESP  = RESP;

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_win;
  logic               r_misal;
  logic               r_wr_en;
  logic               r_rd_en;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic               r_rsp_err;
  logic [DATA_W-1:0]  r_rsp_rdata;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_sel_write;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_sel_aligned;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req   (req_if.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_write   = req_if.req_write[w_idx];
    w_sel_addr    = req_if.req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
    w_sel_wdata   = req_if.req_wdata[int'(w_idx)*DATA_W +: DATA_W];
    w_sel_aligned = addr_aligned(w_sel_addr[1:0]);
  end

  assign w_accept = (r_state == ST_IDLE) && w_any;

  assign req_if.req_ready = w_accept ? w_grant : '0;
  assign req_if.rsp_valid = r_rsp_valid;
  assign req_if.rsp_err   = r_rsp_err;
  assign req_if.rsp_rdata = r_rsp_rdata;

  assign bus_if.wr_en = r_wr_en;
  assign bus_if.rd_en = r_rd_en;
  assign bus_if.addr  = r_addr;
  assign bus_if.wdata = r_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_win       <= '0;
      r_misal     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_ISSUE;
            r_ptr   <= w_idx;
            r_win   <= w_idx;
            r_misal <= !w_sel_aligned;
            // A misaligned command keeps the whole bus quiet, not just the strobes.
            r_wr_en <= w_sel_aligned && w_sel_write;
            r_rd_en <= w_sel_aligned && !w_sel_write;
            r_addr  <= w_sel_aligned ? w_sel_addr : '0;
            r_wdata <= (w_sel_aligned && w_sel_write) ? w_sel_wdata : '0;
          end
        end
        ST_ISSUE: begin
          r_state     <= ST_RESP;
          r_wr_en     <= 1'b0;
          r_rd_en     <= 1'b0;
          r_addr      <= '0;
          r_wdata     <= '0;
          r_rsp_valid <= NUM_REQ'(1) << r_win;
          r_rsp_err   <= r_misal;
          // rd_en is only set for aligned reads, so writes and errors return 0.
          r_rsp_rdata <= r_rd_en ? bus_if.rdata : '0;
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regset_arbiter.sv
module tb_regset_arbiter;
  import regset_pkg::*;

  localparam int NR = 2;
  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regset_req_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) ri ();
  regset_bus_if #(.ADDR_W(AW), .DATA_W(DW)) bi ();

  regset_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_if (ri),
    .bus_if (bi)
  );

  // requester drive state
  logic        t_valid [NR];
  logic        t_write [NR];
  logic [9:0]  t_addr  [NR];
  logic [31:0] t_wdata [NR];

  assign ri.req_valid = {t_valid[1], t_valid[0]};
  assign ri.req_write = {t_write[1], t_write[0]};
  assign ri.req_addr  = {t_addr[1], t_addr[0]};
  assign ri.req_wdata = {t_wdata[1], t_wdata[0]};

  // regset model: DATA0 read/write, DATA0_SR read-only mirror, rest reads 0
  logic [31:0] data0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data0 <= '0;
    else if (bi.wr_en && bi.addr == DATA0_ADDR) data0 <= bi.wdata;
  end
  assign bi.rdata = (bi.rd_en && (bi.addr == DATA0_ADDR || bi.addr == DATA0_SR_ADDR)) ? data0 : 32'h0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int bus_en_cnt = 0;
  int rsp_cnt = 0;
  int acc_cyc [NR];
  int last_grant_cyc [NR];

  exp_t q0 [$];
  exp_t q1 [$];
  int   exp_grant [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event expected none (t=%0t)", name, $time);
  endtask

  // monitor: bus sanity, grant order, response scoreboard
  always @(negedge clk) begin
    int   r;
    int   g;
    exp_t e;
    if (bi.wr_en || bi.rd_en) begin
      bus_en_cnt++;
      check("bus_single_enable", {63'd0, bi.wr_en & bi.rd_en}, 64'd0);
    end
    if (ri.req_ready != '0) begin
      r = ri.req_ready[1] ? 1 : 0;
      if (exp_grant.size() == 0) fail_event("unexpected_grant");
      else begin
        g = exp_grant.pop_front();
        check("grant_onehot", {62'd0, ri.req_ready}, 64'd1 << g);
      end
      acc_cyc[r] = cyc;
      last_grant_cyc[r] = cyc;
    end
    if (ri.rsp_valid != '0) begin
      rsp_cnt++;
      if (ri.rsp_valid == 2'b01) r = 0;
      else if (ri.rsp_valid == 2'b10) r = 1;
      else r = -1;
      if (r < 0) fail_event("rsp_valid_not_onehot");
      else if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) fail_event("unexpected_rsp");
      else begin
        if (r == 0) e = q0.pop_front();
        else e = q1.pop_front();
        check("rsp_err", {63'd0, ri.rsp_err}, {63'd0, e.err});
        check("rsp_rdata", {32'd0, ri.rsp_rdata}, {32'd0, e.rdata});
        check("rsp_latency", 64'(cyc - acc_cyc[r]), 64'd2);
      end
    end
  end

  task automatic do_cmd(input int r, input logic wr, input logic [9:0] a, input logic [31:0] d,
                        input logic err_exp, input logic [31:0] rd_exp);
    exp_t e;
    bit   got;
    e.err = err_exp;
    e.rdata = rd_exp;
    if (r == 0) q0.push_back(e);
    else q1.push_back(e);
    t_write[r] = wr;
    t_addr[r]  = a;
    t_wdata[r] = d;
    t_valid[r] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ri.req_ready[r]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: requester %0d got no ready expected ready within 60 cycles", r);
    end
    @(posedge clk);
    #1;
    t_valid[r] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {57'd0, ri.req_ready, ri.rsp_valid, ri.rsp_err, bi.wr_en, bi.rd_en}, 64'd0);
    check({tag, "_addr"}, {54'd0, bi.addr}, 64'd0);
    check({tag, "_wdata"}, {32'd0, bi.wdata}, 64'd0);
    check({tag, "_rsp_rdata"}, {32'd0, ri.rsp_rdata}, 64'd0);
  endtask

  function automatic logic [31:0] t3_data(input int i);
    return (i == 7) ? 32'hAAAA5555 : (32'h1000_0000 + 32'(i));
  endfunction

  int base;
  int rsp_base;
  bit got6;

  initial begin
    for (int i = 0; i < NR; i++) begin
      t_valid[i] = 1'b0;
      t_write[i] = 1'b0;
      t_addr[i]  = '0;
      t_wdata[i] = '0;
      acc_cyc[i] = 0;
      last_grant_cyc[i] = 0;
    end

    // 1. reset
    rst_n = 1'b0;
    idle(3);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    idle(1);
    check_all_zero("after_reset");
    exp_grant.push_back(0);
    do_cmd(0, 1'b0, 10'h000, 32'h0, 1'b0, 32'h0000_0000);
    idle(4);

    // 2. same-cycle requests from a fresh pointer
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    fork
      do_cmd(0, 1'b1, 10'h000, 32'hAAAA5555, 1'b0, 32'h0);
      do_cmd(1, 1'b0, 10'h004, 32'h0, 1'b0, 32'hAAAA5555);
    join
    idle(4);
    check("t2_grant_gap", 64'(last_grant_cyc[1] - last_grant_cyc[0]), 64'd3);

    // 3. fairness with both held valid
    for (int i = 0; i < 8; i++) begin
      exp_grant.push_back(0);
      exp_grant.push_back(1);
    end
    base = bus_en_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) do_cmd(0, 1'b1, 10'h000, t3_data(i), 1'b0, 32'h0);
      end
      begin
        for (int j = 0; j < 8; j++) do_cmd(1, 1'b0, 10'h004, 32'h0, 1'b0, t3_data(j));
      end
    join
    idle(4);
    check("t3_bus_cycles", 64'(bus_en_cnt - base), 64'd16);

    // 4. read-only and unmapped
    exp_grant.push_back(1);
    do_cmd(1, 1'b1, 10'h004, 32'hFFFFFFFF, 1'b0, 32'h0);
    exp_grant.push_back(0);
    do_cmd(0, 1'b0, 10'h004, 32'h0, 1'b0, 32'hAAAA5555);
    exp_grant.push_back(1);
    do_cmd(1, 1'b0, 10'h100, 32'h0, 1'b0, 32'h0000_0000);
    exp_grant.push_back(0);
    do_cmd(0, 1'b0, 10'h000, 32'h0, 1'b0, 32'hAAAA5555);
    idle(4);

    // 5. misaligned
    base = bus_en_cnt;
    exp_grant.push_back(0);
    do_cmd(0, 1'b0, 10'h002, 32'h0, 1'b1, 32'h0);
    idle(4);
    check("t5_no_bus_access", 64'(bus_en_cnt - base), 64'd0);

    // 6. reset during the ISSUE cycle of a write
    rsp_base = rsp_cnt;
    exp_grant.push_back(0);
    t_write[0] = 1'b1;
    t_addr[0]  = 10'h000;
    t_wdata[0] = 32'h12345678;
    t_valid[0] = 1'b1;
    got6 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ri.req_ready[0]) begin
        got6 = 1'b1;
        break;
      end
    end
    check("t6_accepted", {63'd0, got6}, 64'd1);
    @(posedge clk);
    #1;
    t_valid[0] = 1'b0;
    check("t6_wr_en_in_issue", {63'd0, bi.wr_en}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_wr_en_async_drop", {63'd0, bi.wr_en}, 64'd0);
    idle(3);
    check_all_zero("t6_in_reset");
    rst_n = 1'b1;
    idle(4);
    check("t6_no_rsp", 64'(rsp_cnt - rsp_base), 64'd0);
    exp_grant.push_back(0);
    do_cmd(0, 1'b0, 10'h000, 32'h0, 1'b0, 32'h0000_0000);
    idle(4);

    check("sb_q0_drained", 64'(q0.size()), 64'd0);
    check("sb_q1_drained", 64'(q1.size()), 64'd0);
    check("sb_grants_drained", 64'(exp_grant.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000 time units");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule
